// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor (2-bit BHT + BTB) for IF, with the IF/ID prediction register and ID-stage training.
// Optional BPU_TAG_CHECK_EN: store BTB tags and require a tag match for a hit; otherwise hit = valid only.
module branch_predict_unit #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned PC_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] PC_curr,
    input  logic            PC_stall,
    input  logic            IF_ID_stall,
    input  logic            IF_flush,
    output logic            predicted_taken,
    output logic [PC_W-1:0] predicted_target,
    output logic            IF_ID_predicted_taken,
    output logic [PC_W-1:0] IF_ID_predicted_target,
    output logic [PC_W-1:0] IF_ID_PC_curr,
    input  logic            ID_is_branch,
    input  logic            actual_taken,
    input  logic [PC_W-1:0] actual_target,
    output logic            branch_mispredicted
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;
    localparam int unsigned TAG_W = PC_W - INDEX_BITS - 1;

    logic [DEPTH-1:0][1:0]      bht;
    logic [DEPTH-1:0]           btb_valid;
    logic [DEPTH-1:0][PC_W-1:0] btb_target;
`ifdef BPU_TAG_CHECK_EN
    logic [DEPTH-1:0][TAG_W-1:0] btb_tag;
`endif

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic                  hit;
    logic                  train;
    logic [1:0]            cnt_next;
    logic                  pc_stall_unused;

    // PC_stall only freezes the fetch PC upstream; the lookup simply repeats.
    assign pc_stall_unused = PC_stall;

    // Lookup reads pre-update table contents; no bypass from a same-cycle training write.
    assign rd_idx = PC_curr[INDEX_BITS:1];
`ifdef BPU_TAG_CHECK_EN
    assign hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == PC_curr[PC_W-1:INDEX_BITS+1]);
`else
    assign hit = btb_valid[rd_idx];
`endif
    assign predicted_taken  = hit & bht[rd_idx][1];
    assign predicted_target = hit ? btb_target[rd_idx] : '0;

    // A branch is resolved only in the cycle it leaves ID, so a stall blocks both training and reporting.
    assign train  = ID_is_branch & ~IF_ID_stall;
    assign wr_idx = IF_ID_PC_curr[INDEX_BITS:1];

    assign branch_mispredicted = train &
        ((IF_ID_predicted_taken ^ actual_taken) |
         (actual_taken & (IF_ID_predicted_target != actual_target)));

    // Saturating 2-bit counter step for the resolving branch.
    always_comb begin
        cnt_next = bht[wr_idx];
        if (actual_taken) begin
            if (cnt_next != 2'b11) cnt_next = cnt_next + 2'b01;
        end else begin
            if (cnt_next != 2'b00) cnt_next = cnt_next - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht        <= {DEPTH{2'b01}};
            btb_valid  <= '0;
            btb_target <= '0;
`ifdef BPU_TAG_CHECK_EN
            btb_tag    <= '0;
`endif
        end else if (train) begin
            bht[wr_idx] <= cnt_next;
            if (actual_taken) begin
                btb_valid[wr_idx]  <= 1'b1;
                btb_target[wr_idx] <= actual_target;
`ifdef BPU_TAG_CHECK_EN
                btb_tag[wr_idx]    <= IF_ID_PC_curr[PC_W-1:INDEX_BITS+1];
`endif
            end
        end
    end

    // IF/ID prediction register: flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IF_ID_predicted_taken  <= 1'b0;
            IF_ID_predicted_target <= '0;
            IF_ID_PC_curr          <= '0;
        end else if (IF_flush) begin
            IF_ID_predicted_taken  <= 1'b0;
            IF_ID_predicted_target <= '0;
            IF_ID_PC_curr          <= '0;
        end else if (!IF_ID_stall) begin
            IF_ID_predicted_taken  <= predicted_taken;
            IF_ID_predicted_target <= predicted_target;
            IF_ID_PC_curr          <= PC_curr;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: expectations are queued per step and checked at the falling edge.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] PC_curr;
    logic        PC_stall;
    logic        IF_ID_stall;
    logic        IF_flush;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic        IF_ID_predicted_taken;
    logic [15:0] IF_ID_predicted_target;
    logic [15:0] IF_ID_PC_curr;
    logic        ID_is_branch;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        branch_mispredicted;

    branch_predict_unit #(.INDEX_BITS(3), .PC_W(16)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .PC_curr                (PC_curr),
        .PC_stall               (PC_stall),
        .IF_ID_stall            (IF_ID_stall),
        .IF_flush               (IF_flush),
        .predicted_taken        (predicted_taken),
        .predicted_target       (predicted_target),
        .IF_ID_predicted_taken  (IF_ID_predicted_taken),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .ID_is_branch           (ID_is_branch),
        .actual_taken           (actual_taken),
        .actual_target          (actual_target),
        .branch_mispredicted    (branch_mispredicted)
    );

    always #5 clk = ~clk;

    localparam int PT = 0, PTGT = 1, QPT = 2, QTGT = 3, QPC = 4, MISP = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            PT:      return {15'b0, predicted_taken};
            PTGT:    return predicted_target;
            QPT:     return {15'b0, IF_ID_predicted_taken};
            QTGT:    return IF_ID_predicted_target;
            QPC:     return IF_ID_PC_curr;
            MISP:    return {15'b0, branch_mispredicted};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [15:0] pc, input logic pstall, input logic stall,
                         input logic flush, input logic br, input logic tk,
                         input logic [15:0] tgt);
        PC_curr       = pc;
        PC_stall      = pstall;
        IF_ID_stall   = stall;
        IF_flush      = flush;
        ID_is_branch  = br;
        actual_taken  = tk;
        actual_target = tgt;
    endtask

    // Drain the scoreboard at the falling edge, then advance to just after the next rising edge.
    task automatic check_step();
        exp_t        e;
        logic [15:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed 0x%04h expected 0x%04h", e.tag, o, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        #2;
        push_exp("rst_pt", PT, 16'h0000);
        push_exp("rst_ptgt", PTGT, 16'h0000);
        push_exp("rst_qpt", QPT, 16'h0000);
        push_exp("rst_qtgt", QTGT, 16'h0000);
        push_exp("rst_qpc", QPC, 16'h0000);
        push_exp("rst_misp", MISP, 16'h0000);
        check_step();
        rst_n = 1'b1;

        // Fetch 0x0010 with nothing resolving.
        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("s1_pt", PT, 16'h0000);
        push_exp("s1_qpc", QPC, 16'h0000);
        check_step();

        // First taken resolution: predicted NT so mispredicted; same-cycle lookup sees old tables.
        drive(16'h0010, 0, 0, 0, 1, 1, 16'h0040);
        push_exp("s2_pt_nobypass", PT, 16'h0000);
        push_exp("s2_qpc", QPC, 16'h0010);
        push_exp("s2_misp", MISP, 16'h0001);
        check_step();

        // Counter now 10: lookup predicts taken to 0x0040.
        drive(16'h0010, 0, 0, 0, 1, 1, 16'h0040);
        push_exp("s3_pt", PT, 16'h0001);
        push_exp("s3_ptgt", PTGT, 16'h0040);
        push_exp("s3_misp", MISP, 16'h0001);
        check_step();

        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("s4_pt", PT, 16'h0001);
        push_exp("s4_qpt", QPT, 16'h0001);
        push_exp("s4_qtgt", QTGT, 16'h0040);
        push_exp("s4_misp", MISP, 16'h0000);
        check_step();

        // Predicted taken, resolves not taken: counter 11 -> 10, BTB kept.
        drive(16'h0010, 0, 0, 0, 1, 0, 16'h0012);
        push_exp("s5_misp", MISP, 16'h0001);
        check_step();

        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("s6_pt", PT, 16'h0001);
        push_exp("s6_ptgt_kept", PTGT, 16'h0040);
        push_exp("s6_misp_once", MISP, 16'h0000);
        check_step();

        // Two more not-taken: 10 -> 01 -> 00.
        drive(16'h0010, 0, 0, 0, 1, 0, 16'h0012);
        push_exp("s7_misp", MISP, 16'h0001);
        check_step();
        drive(16'h0010, 0, 0, 0, 1, 0, 16'h0012);
        push_exp("s8_pt", PT, 16'h0000);
        push_exp("s8_ptgt_hit", PTGT, 16'h0040);
        push_exp("s8_misp", MISP, 16'h0001);
        check_step();

        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("s9_qpt", QPT, 16'h0000);
        push_exp("s9_qtgt", QTGT, 16'h0040);
        check_step();

        // Branch held in ID for three cycles while the fetch PC moves on.
        for (int i = 0; i < 3; i++) begin
            drive(16'h0030, 1, 1, 0, 1, 1, 16'h0040);
            push_exp($sformatf("stall%0d_misp", i), MISP, 16'h0000);
            push_exp($sformatf("stall%0d_qpc", i), QPC, 16'h0010);
            push_exp($sformatf("stall%0d_qpt", i), QPT, 16'h0000);
            check_step();
        end

        // Release: one training update 00 -> 01.
        drive(16'h0010, 0, 0, 0, 1, 1, 16'h0040);
        push_exp("rel_misp", MISP, 16'h0001);
        push_exp("rel_qpc", QPC, 16'h0010);
        check_step();
        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("rel_pt_single_inc", PT, 16'h0000);
        check_step();

        // PC_stall high must not block training: 01 -> 10.
        drive(16'h0010, 1, 0, 0, 1, 1, 16'h0040);
        check_step();
        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("pcstall_pt", PT, 16'h0001);
        check_step();

        // Flush and stall together: flush wins.
        drive(16'h0010, 0, 1, 1, 0, 0, 16'h0000);
        push_exp("fl_pre_qpt", QPT, 16'h0001);
        push_exp("fl_pre_qpc", QPC, 16'h0010);
        check_step();
        drive(16'h0010, 0, 1, 0, 0, 0, 16'h0000);
        push_exp("fl_qpt", QPT, 16'h0000);
        push_exp("fl_qtgt", QTGT, 16'h0000);
        push_exp("fl_qpc", QPC, 16'h0000);
        check_step();

        // 0x0020 aliases index 0 with a different tag.
        drive(16'h0020, 0, 0, 0, 0, 0, 16'h0000);
`ifdef BPU_TAG_CHECK_EN
        push_exp("alias_pt", PT, 16'h0000);
        push_exp("alias_ptgt", PTGT, 16'h0000);
`else
        push_exp("alias_pt", PT, 16'h0001);
        push_exp("alias_ptgt", PTGT, 16'h0040);
`endif
        check_step();

        // Mid-operation reset clears everything immediately.
        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        rst_n = 1'b0;
        push_exp("mrst_pt", PT, 16'h0000);
        push_exp("mrst_ptgt", PTGT, 16'h0000);
        push_exp("mrst_qpc", QPC, 16'h0000);
        push_exp("mrst_misp", MISP, 16'h0000);
        check_step();
        rst_n = 1'b1;
        drive(16'h0010, 0, 0, 0, 0, 0, 16'h0000);
        push_exp("post_rst_pt", PT, 16'h0000);
        push_exp("post_rst_ptgt", PTGT, 16'h0000);
        check_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
